// File: rtl/pipe_flow_ctrl.sv
// pipe_flow_ctrl: valid/ready sequencing for a companion register_pipe.
// Tracks which pipe slots hold live data, drives the pipe clock enable,
// stalls the whole pipe on downstream backpressure and supports a
// synchronous flush. No data passes through this block.
module pipe_flow_ctrl #(
    parameter int DEPTH = 6,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    input  logic                       flush,
    output logic                       ce,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [1:0]                 state,
    output logic [CNT_W-1:0]           stall_cnt
);

    localparam int OCC_W = $clog2(DEPTH+1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [DEPTH-1:0] v_reg;
    logic [DEPTH-1:0] v_next;
    logic [DEPTH-1:0] v_shift;
    logic [OCC_W-1:0] occ_reg;
    logic [OCC_W-1:0] occ_next;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic             stall;
    logic             in_fire;
    logic             out_fire;

    // Valid vector advanced by one slot: new input enters slot 0, slot
    // DEPTH-1 mirrors the pipe's dout.
    assign v_shift[0] = in_valid;
    genvar gi;
    generate
        for (gi = 1; gi < DEPTH; gi++) begin : g_shift
            assign v_shift[gi] = v_reg[gi-1];
        end
    endgenerate

    // Handshake and enable are purely combinational on the live valid vector,
    // so backpressure freezes the pipe in the same cycle out_ready drops.
    always_comb begin
        stall     = v_reg[DEPTH-1] & ~out_ready;
        ce        = ~flush & (state_reg != FLUSH) & ~stall;
        in_ready  = ce;
        out_valid = v_reg[DEPTH-1] & ~flush & (state_reg != FLUSH);
        in_fire   = ce & in_valid;
        out_fire  = ce & v_reg[DEPTH-1];
    end

    // Next valid vector, occupancy and state; flush outranks any fire.
    always_comb begin
        v_next     = v_reg;
        occ_next   = occ_reg;
        state_next = state_reg;
        if (flush) begin
            v_next     = '0;
            occ_next   = '0;
            state_next = FLUSH;
        end else if (state_reg == FLUSH) begin
            v_next     = '0;
            occ_next   = '0;
            state_next = IDLE;
        end else begin
            if (ce) begin
                v_next   = v_shift;
                occ_next = occ_reg + OCC_W'(in_fire) - OCC_W'(out_fire);
            end
            if (v_next[DEPTH-1] && !out_ready) begin
                state_next = STALL;
            end else if (occ_next != '0) begin
                state_next = RUN;
            end else begin
                state_next = IDLE;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_reg     <= '0;
            occ_reg   <= '0;
            state_reg <= IDLE;
        end else begin
            v_reg     <= v_next;
            occ_reg   <= occ_next;
            state_reg <= state_next;
        end
    end

    // Saturating count of cycles with the output held by backpressure.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_reg <= '0;
        end else if (stall && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
        end
    end

    assign occupancy = occ_reg;
    assign state     = state_reg;
    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Testbench for pipe_flow_ctrl: directed scenarios plus randomized traffic,
// checked each cycle against an item-list model of the pipe.
module tb_pipe_flow_ctrl;

    localparam int DEPTH = 6;
    localparam int CNT_W = 16;
    localparam int OCC_W = $clog2(DEPTH+1);
    localparam int EW    = OCC_W + 5;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b1;
    logic             flush = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic             ce;
    logic [OCC_W-1:0] occupancy;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic [EW-1:0]    obs;

    always #5 clk = ~clk;

    pipe_flow_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
        .ce(ce), .occupancy(occupancy), .state(state), .stall_cnt(stall_cnt)
    );

    assign obs = {ce, in_ready, out_valid, occupancy, state};

    int checks = 0;
    int failures = 0;

    // Model: each in-flight item carries its slot position (0 = just entered,
    // DEPTH-1 = at dout). Items leave in order, so the queue front is oldest.
    int               pos_q[$];
    int               id_q[$];
    int               m_state;
    logic [CNT_W-1:0] m_stall_cnt;
    int               next_id = 0;

    function automatic bit m_head();
        return (pos_q.size() > 0) && (pos_q[0] == DEPTH-1);
    endfunction

    function automatic logic [EW-1:0] model_exp();
        bit stl, cen, ov;
        stl = m_head() && !out_ready;
        cen = !flush && (m_state != 3) && !stl;
        ov  = m_head() && !flush && (m_state != 3);
        return {cen, cen, ov, OCC_W'(pos_q.size()), 2'(m_state)};
    endfunction

    function automatic void model_reset();
        pos_q.delete();
        id_q.delete();
        m_state     = 0;
        m_stall_cnt = '0;
    endfunction

    function automatic void model_update();
        bit stl, cen, head;
        head = m_head();
        stl  = head && !out_ready;
        cen  = !flush && (m_state != 3) && !stl;
        if (stl && (m_stall_cnt != {CNT_W{1'b1}})) m_stall_cnt++;
        if (flush) begin
            pos_q.delete();
            id_q.delete();
            m_state = 3;
        end else if (m_state == 3) begin
            m_state = 0;
        end else begin
            if (cen) begin
                if (head) begin
                    void'(pos_q.pop_front());
                    $display("xfer out item=%0d t=%0t", id_q.pop_front(), $time);
                end
                foreach (pos_q[i]) pos_q[i]++;
                if (in_valid) begin
                    pos_q.push_back(0);
                    id_q.push_back(next_id);
                    next_id++;
                end
            end
            if (m_head() && !out_ready) m_state = 2;
            else if (pos_q.size() > 0)  m_state = 1;
            else                        m_state = 0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        flush = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        model_reset();
        #1;
        checks++;
        if (obs !== {1'b1, 1'b1, 1'b0, {OCC_W{1'b0}}, 2'd0}) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=%b", obs, {1'b1, 1'b1, 1'b0, {OCC_W{1'b0}}, 2'd0});
        end
        checks++;
        if (stall_cnt !== '0) begin
            failures++;
            $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single();
        int ov_cnt = 0;
        int ov_k = -1;
        do_reset();
        for (int k = 0; k < DEPTH + 6; k++) begin
            in_valid = (k == 0);
            out_ready = 1'b1;
            #1;
            checks++;
            if (obs !== model_exp()) begin
                failures++;
                $display("FAIL single cyc=%0d got=%b exp=%b", k, obs, model_exp());
            end
            checks++;
            if (occupancy !== OCC_W'((k >= 1 && k <= DEPTH) ? 1 : 0)) begin
                failures++;
                $display("FAIL single_occ cyc=%0d got=%0d", k, occupancy);
            end
            if (out_valid) begin
                ov_cnt++;
                ov_k = k;
            end
            tick();
        end
        checks++;
        if (ov_cnt != 1 || ov_k != DEPTH) begin
            failures++;
            $display("FAIL single_latency got count=%0d cyc=%0d exp count=1 cyc=%0d", ov_cnt, ov_k, DEPTH);
        end
    endtask

    task automatic test_stream();
        int ov_cnt = 0;
        int first = -1;
        int last = -1;
        int occ_max = 0;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            in_valid = (k < 10);
            out_ready = 1'b1;
            #1;
            checks++;
            if (obs !== model_exp()) begin
                failures++;
                $display("FAIL stream cyc=%0d got=%b exp=%b", k, obs, model_exp());
            end
            if (out_valid) begin
                ov_cnt++;
                if (first < 0) first = k;
                last = k;
            end
            if (int'(occupancy) > occ_max) occ_max = int'(occupancy);
            tick();
        end
        checks++;
        if (ov_cnt != 10 || (last - first + 1) != 10) begin
            failures++;
            $display("FAIL stream_count got=%0d span=%0d exp=10", ov_cnt, last - first + 1);
        end
        checks++;
        if (occ_max != DEPTH || stall_cnt !== '0) begin
            failures++;
            $display("FAIL stream_occ got occ_max=%0d stall_cnt=%0d exp %0d/0", occ_max, stall_cnt, DEPTH);
        end
    endtask

    task automatic test_stall();
        int drained = 0;
        do_reset();
        for (int k = 0; k < DEPTH + 5 + 8; k++) begin
            if (k < DEPTH) begin
                in_valid = 1'b1;
                out_ready = 1'b0;
            end else if (k < DEPTH + 5) begin
                in_valid = 1'($urandom_range(0, 1));
                out_ready = 1'b0;
            end else begin
                in_valid = 1'b0;
                out_ready = 1'b1;
            end
            #1;
            checks++;
            if (obs !== model_exp() || stall_cnt !== m_stall_cnt) begin
                failures++;
                $display("FAIL stall cyc=%0d got=%b/%0d exp=%b/%0d", k, obs, stall_cnt, model_exp(), m_stall_cnt);
            end
            if (k >= DEPTH && k < DEPTH + 5) begin
                checks++;
                if ({ce, in_ready, state} !== {1'b0, 1'b0, 2'd2}) begin
                    failures++;
                    $display("FAIL stall_hold cyc=%0d got ce=%b rdy=%b st=%0d exp 0/0/2", k, ce, in_ready, state);
                end
            end
            if (k == DEPTH + 5) begin
                checks++;
                if (stall_cnt !== CNT_W'(5) || occupancy !== OCC_W'(DEPTH)) begin
                    failures++;
                    $display("FAIL stall_count got cnt=%0d occ=%0d exp 5/%0d", stall_cnt, occupancy, DEPTH);
                end
            end
            if (k >= DEPTH + 5 && k < DEPTH + 5 + DEPTH && out_valid && out_ready) drained++;
            tick();
        end
        checks++;
        if (drained != DEPTH) begin
            failures++;
            $display("FAIL stall_drain got=%0d exp=%0d", drained, DEPTH);
        end
    endtask

    task automatic test_alternating();
        do_reset();
        for (int k = 0; k < 40; k++) begin
            in_valid = (k % 2 == 0) && (k < 30);
            out_ready = m_head() ? 1'b1 : 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (obs !== model_exp()) begin
                failures++;
                $display("FAIL alternating cyc=%0d got=%b exp=%b", k, obs, model_exp());
            end
            tick();
        end
        checks++;
        if (stall_cnt !== '0) begin
            failures++;
            $display("FAIL alternating_stall_cnt got=%0d exp=0", stall_cnt);
        end
    endtask

    task automatic test_flush();
        int ov_cnt = 0;
        int ov_k = -1;
        do_reset();
        for (int k = 0; k < DEPTH + 10; k++) begin
            in_valid = (k < 3) || (k == 6);
            flush = (k == 4);
            out_ready = 1'b1;
            #1;
            checks++;
            if (obs !== model_exp()) begin
                failures++;
                $display("FAIL flush cyc=%0d got=%b exp=%b", k, obs, model_exp());
            end
            if (k == 4 || k == 5) begin
                checks++;
                if ({in_ready, out_valid} !== 2'b00 || (k == 5 && (state !== 2'd3 || occupancy !== '0))) begin
                    failures++;
                    $display("FAIL flush_block cyc=%0d got rdy=%b ov=%b st=%0d occ=%0d", k, in_ready, out_valid, state, occupancy);
                end
            end
            if (k == 6) begin
                checks++;
                if (state !== 2'd0 || in_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL flush_resume got st=%0d rdy=%b exp 0/1", state, in_ready);
                end
            end
            if (out_valid) begin
                ov_cnt++;
                ov_k = k;
            end
            tick();
        end
        flush = 1'b0;
        checks++;
        if (ov_cnt != 1 || ov_k != 6 + DEPTH) begin
            failures++;
            $display("FAIL flush_emerge got count=%0d cyc=%0d exp 1/%0d", ov_cnt, ov_k, 6 + DEPTH);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            in_valid = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < 70);
            flush = ($urandom_range(0, 99) < 3);
            #1;
            checks++;
            if (obs !== model_exp() || stall_cnt !== m_stall_cnt) begin
                failures++;
                $display("FAIL random cyc=%0d got=%b/%0d exp=%b/%0d", k, obs, stall_cnt, model_exp(), m_stall_cnt);
            end
            tick();
        end
        flush = 1'b0;
    endtask

    task automatic test_reset_midstall();
        do_reset();
        for (int k = 0; k < DEPTH + 3; k++) begin
            in_valid = (k < DEPTH);
            out_ready = 1'b0;
            #1;
            checks++;
            if (obs !== model_exp() || stall_cnt !== m_stall_cnt) begin
                failures++;
                $display("FAIL midstall cyc=%0d got=%b/%0d exp=%b/%0d", k, obs, stall_cnt, model_exp(), m_stall_cnt);
            end
            tick();
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== {1'b1, 1'b1, 1'b0, {OCC_W{1'b0}}, 2'd0} || stall_cnt !== '0) begin
            failures++;
            $display("FAIL async_reset got=%b cnt=%0d exp=%b cnt=0", obs, stall_cnt, {1'b1, 1'b1, 1'b0, {OCC_W{1'b0}}, 2'd0});
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 12; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            out_ready = 1'b1;
            #1;
            checks++;
            if (obs !== model_exp()) begin
                failures++;
                $display("FAIL after_reset cyc=%0d got=%b exp=%b", k, obs, model_exp());
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_stall();
        test_alternating();
        test_flush();
        test_random();
        test_reset_midstall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
